cp_insert: RTL and testbench
============================

CP_INSERT -- requirements
Module: cp_insert

Interface
REQ-001 SHALL have parameter IN_DW, default 32, complex sample width ({im, re}, each IN_DW/2).
REQ-002 SHALL have parameter NFFT, default 8, log2 of symbol length; localparam FFT_LEN = 2**NFFT.
REQ-003 SHALL have parameter CP_LEN, default 18, cyclic prefix length; legal range 1..FFT_LEN-1.
REQ-004 SHALL use one clock; reset is asynchronous and active-low.
REQ-005 clk_i  input  1  clock; all logic on the rising edge.
REQ-006 reset_ni  input  1  asynchronous active-low reset.
REQ-007 s_axis_in_tdata  input  IN_DW  time-domain IFFT output sample.
REQ-008 s_axis_in_tvalid  input  1  input sample valid.
REQ-009 s_axis_in_tready  output  1  block accepts input.
REQ-010 m_axis_out_tdata  output  IN_DW  CP-prefixed OFDM sample.
REQ-011 m_axis_out_tvalid  output  1  output valid.
REQ-012 m_axis_out_tready  input  1  downstream accepts output.
REQ-013 symbol_start_o  output  1  high with the first CP sample of each output symbol.

Function
REQ-014 SHALL hold two symbol banks (ping/pong) of FFT_LEN samples each; bank state EMPTY or FULL.
REQ-015 Input transfer occurs when tvalid && tready; write index counts 0..FFT_LEN-1 in the current write bank and wraps.
REQ-016 When write index FFT_LEN-1 transfers, the write bank SHALL become FULL and writing SHALL toggle to the other bank.
REQ-017 s_axis_in_tready SHALL be high exactly when the current write bank is EMPTY.
REQ-018 Read FSM states: IDLE (read bank EMPTY), CP (emit indices FFT_LEN-CP_LEN..FFT_LEN-1), BODY (emit indices 0..FFT_LEN-1).
REQ-019 IDLE->CP when the read bank is FULL; CP->BODY after the CP_LEN-th CP sample is issued; after BODY index FFT_LEN-1 is issued, the bank becomes EMPTY, read toggles, and the FSM goes to CP if the new bank is FULL, else IDLE.
REQ-020 Each symbol SHALL produce exactly FFT_LEN+CP_LEN output transfers; output sample k<CP_LEN equals input sample FFT_LEN-CP_LEN+k, and output CP_LEN+n equals input n.
REQ-021 Output SHALL obey AXI-stream: tdata/tvalid stable while tvalid && !tready; no sample lost or duplicated under arbitrary tready.
REQ-022 With continuous input and tready held high, output SHALL be gap-free across symbol boundaries; the first output valid SHALL appear no later than 3 cycles after the last input sample of the first symbol is transferred.
REQ-023 Simultaneous write-completion on one bank and read-completion on the other in the same cycle SHALL update both bank states correctly.
REQ-024 A bank SHALL NOT be written while it is FULL or being read; input back-pressure is the only flow control.
REQ-025 symbol_start_o SHALL be asserted on the same cycle as the valid for output index 0 of the CP and held while that beat stalls.

Reset
REQ-026 On reset: both banks EMPTY, write and read bank pointers 0, indices 0, FSM IDLE, m_axis_out_tvalid 0, m_axis_out_tdata 0, symbol_start_o 0, s_axis_in_tready 0 while reset is asserted and 1 from the first cycle after release.
REQ-027 Reset mid-symbol SHALL discard all partially written and partially read symbols; no stale sample is emitted after release.

Configuration
REQ-028 Macro CP_INSERT_TLAST_EN: when defined, an extra output m_axis_out_tlast (1 bit) SHALL be present and high on the last BODY sample (index FFT_LEN-1) of each symbol; when undefined the port and its logic SHALL be absent, with other behaviour unchanged.

Structure
REQ-029 Shared package SHALL hold the read-FSM state enum (IDLE, CP, BODY) and the bank-state type; FFT_LEN derivation stays in the module.
REQ-030 Sub-module cp_insert_ram: simple dual-port RAM, depth 2*FFT_LEN, width IN_DW, synchronous 1-cycle read; cp_insert absorbs the read latency with a 2-entry output skid buffer.

Verification
REQ-031 Defaults, one symbol of samples n = 0..255 (re = n, im = 0), tready=1 -> 274 outputs: re 238..255 then 0..255; symbol_start_o on the first only.
REQ-032 Three back-to-back symbols, continuous input, tready=1 -> 822 gap-free outputs after the first valid; s_axis_in_tready drops only when both banks are FULL.
REQ-033 Random tready (50%) over 4 symbols -> output sequence identical to REQ-031 pattern per symbol, no loss/duplication, tdata stable during stalls.
REQ-034 tready=0 held after 2 symbols written -> s_axis_in_tready goes 0 after 512 input transfers; after tready=1 returns, output resumes from the same held beat.
REQ-035 Assert reset_ni=0 after 100 input samples and 50 output transfers -> all outputs at reset values; after release a fresh symbol gives the REQ-031 pattern.
REQ-036 CP_LEN=1 and CP_LEN=255 builds, with and without CP_INSERT_TLAST_EN -> 257 / 511 outputs per symbol, tlast only on the final sample when enabled.

Source files
------------

// File: rtl/cp_insert_pkg.sv
// -----------------------------------------------------------------------------
// cp_insert_pkg
//   Shared types for the cyclic-prefix inserter: the read-side sequencer state
//   and the per-bank fill state of the ping/pong symbol store.
// -----------------------------------------------------------------------------
package cp_insert_pkg;

  // Read sequencer: waiting for a full bank, emitting the prefix, emitting
  // the symbol body.
  typedef enum logic [1:0] {
    RD_IDLE = 2'd0,
    RD_CP   = 2'd1,
    RD_BODY = 2'd2
  } rd_state_e;

  // A bank is either free for the writer or holds a complete symbol.
  typedef enum logic {
    BANK_EMPTY = 1'b0,
    BANK_FULL  = 1'b1
  } bank_state_e;

endpackage : cp_insert_pkg

// File: rtl/cp_insert_if.sv
// -----------------------------------------------------------------------------
// cp_insert_if
//   Minimal AXI-stream bundle used for both the sample input and the
//   CP-prefixed output of cp_insert.
//
//   Parameter: DW - tdata width.
//   Signals  : tdata, tvalid, tready, and tlast when CP_INSERT_TLAST_EN is
//              defined.
//   Modports : master - drives tdata/tvalid(/tlast), receives tready.
//              slave  - receives tdata/tvalid, drives tready.
//
//   Optional feature macro: CP_INSERT_TLAST_EN.
// -----------------------------------------------------------------------------
interface cp_insert_if #(
  parameter int DW = 32
) ();

  logic [DW-1:0] tdata;
  logic          tvalid;
  logic          tready;
`ifdef CP_INSERT_TLAST_EN
  logic          tlast;
`endif

`ifdef CP_INSERT_TLAST_EN
  modport master (output tdata, output tvalid, output tlast, input tready);
`else
  modport master (output tdata, output tvalid, input tready);
`endif

  // The inserter ignores tlast on its input side, so the slave view omits it.
  modport slave (input tdata, input tvalid, output tready);

endinterface : cp_insert_if

// File: rtl/cp_insert_ram.sv
// -----------------------------------------------------------------------------
// cp_insert_ram
//   Simple dual-port RAM holding both symbol banks: one write port, one read
//   port with a registered (1-cycle) read.
//
//   Parameters: DW - word width, AW - address width (depth 2**AW).
//   Ports     : clk_i              clock
//               wr_en/wr_addr/wr_data  write port
//               rd_en/rd_addr          read request
//               rd_data                data for the request of the previous cycle
// -----------------------------------------------------------------------------
module cp_insert_ram #(
  parameter int DW = 32,
  parameter int AW = 9
) (
  input  logic          clk_i,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] mem [2**AW];

  // NOTE: the storage array has no reset; a reset port here would stop it
  // mapping onto block RAM, and the bank flags already mark it as invalid.
  always_ff @(posedge clk_i) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule : cp_insert_ram

// File: rtl/cp_insert.sv
// -----------------------------------------------------------------------------
// cp_insert
//   Cyclic-prefix inserter. Time-domain symbols of FFT_LEN samples are stored
//   in a ping/pong pair of banks; each stored symbol is emitted as its last
//   CP_LEN samples followed by the whole symbol.
//
//   Parameters: IN_DW  - complex sample width ({im, re})
//               NFFT   - log2 of the symbol length
//               CP_LEN - prefix length, 1..FFT_LEN-1
//   Ports     : clk_i          clock (rising edge)
//               reset_ni       asynchronous active-low reset
//               s_axis_in      input sample stream (slave)
//               m_axis_out     CP-prefixed output stream (master)
//               symbol_start_o high with the first prefix beat of each symbol
//
//   Optional feature macro: CP_INSERT_TLAST_EN adds m_axis_out.tlast, high on
//   the final body sample of each symbol.
// -----------------------------------------------------------------------------
module cp_insert
  import cp_insert_pkg::*;
#(
  parameter int IN_DW  = 32,
  parameter int NFFT   = 8,
  parameter int CP_LEN = 18
) (
  input  logic       clk_i,
  input  logic       reset_ni,
  cp_insert_if.slave  s_axis_in,
  cp_insert_if.master m_axis_out,
  output logic       symbol_start_o
);

  localparam int FFT_LEN = 2**NFFT;
  localparam int AW      = NFFT + 1;
  localparam logic [NFFT-1:0] IDX_LAST = NFFT'(FFT_LEN - 1);
  localparam logic [NFFT-1:0] CP_FIRST = NFFT'(FFT_LEN - CP_LEN);

  // One entry of the output skid buffer: a sample plus its framing flags.
  typedef struct packed {
    logic [IN_DW-1:0] data;
    logic             sos;
`ifdef CP_INSERT_TLAST_EN
    logic             last;
`endif
  } beat_t;

  // ---------------------------------------------------------------- write side
  logic            ready_en;
  logic            wr_bank;
  logic [NFFT-1:0] wr_idx;
  bank_state_e     bank_st [2];
  logic            in_fire;
  logic            wr_done;

  // ready_en keeps tready low while reset is asserted and rises on the first
  // clock after release.
  assign s_axis_in.tready = ready_en && (bank_st[wr_bank] == BANK_EMPTY);
  assign in_fire          = s_axis_in.tvalid && s_axis_in.tready;
  assign wr_done          = in_fire && (wr_idx == IDX_LAST);

  // ----------------------------------------------------------------- read side
  rd_state_e       rd_state;
  logic            rd_bank;
  logic [NFFT-1:0] rd_idx;
  logic            rd_vld_q;
  logic            rd_sos_q;
`ifdef CP_INSERT_TLAST_EN
  logic            rd_last_q;
`endif
  logic [IN_DW-1:0] ram_rd_data;

  beat_t           skid [2];
  logic            skid_wptr;
  logic            skid_rptr;
  logic [1:0]      skid_cnt;

  logic            out_pop;
  logic [2:0]      occ;
  logic            rd_issue;
  logic            rd_done;
  beat_t           push_beat;

  assign out_pop = m_axis_out.tvalid && m_axis_out.tready;

  // Slots the skid buffer will hold next cycle, counting the read already in
  // flight. A new read lands one cycle later, so issue only while at most one
  // slot is committed: this sustains one beat per cycle without overflow.
  assign occ      = {1'b0, skid_cnt} + {2'b00, rd_vld_q} - {2'b00, out_pop};
  assign rd_issue = (rd_state != RD_IDLE) && (occ <= 3'd1);
  assign rd_done  = rd_issue && (rd_state == RD_BODY) && (rd_idx == IDX_LAST);

  cp_insert_ram #(
    .DW (IN_DW),
    .AW (AW)
  ) u_ram (
    .clk_i   (clk_i),
    .wr_en   (in_fire),
    .wr_addr ({wr_bank, wr_idx}),
    .wr_data (s_axis_in.tdata),
    .rd_en   (rd_issue),
    .rd_addr ({rd_bank, rd_idx}),
    .rd_data (ram_rd_data)
  );

  // Writer pointers and bank flags. The writer only fills an EMPTY bank and
  // the reader only drains a FULL one, so the two updates below never target
  // the same bank in one cycle.
  // NOTE: every state register uses non-blocking assignment so all flops
  // sample the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      ready_en   <= 1'b0;
      wr_bank    <= 1'b0;
      wr_idx     <= '0;
      bank_st[0] <= BANK_EMPTY;
      bank_st[1] <= BANK_EMPTY;
    end else begin
      ready_en <= 1'b1;
      if (in_fire) begin
        wr_idx <= wr_idx + 1'b1;
        if (wr_done) wr_bank <= ~wr_bank;
      end
      for (int b = 0; b < 2; b++) begin
        if (wr_done && (wr_bank == 1'(b)))      bank_st[b] <= BANK_FULL;
        else if (rd_done && (rd_bank == 1'(b))) bank_st[b] <= BANK_EMPTY;
      end
    end
  end

  // Read sequencer. rd_idx is the sample address inside the bank: the prefix
  // walks CP_FIRST..FFT_LEN-1 and wraps naturally to 0 for the body.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      rd_state  <= RD_IDLE;
      rd_bank   <= 1'b0;
      rd_idx    <= '0;
      rd_vld_q  <= 1'b0;
      rd_sos_q  <= 1'b0;
`ifdef CP_INSERT_TLAST_EN
      rd_last_q <= 1'b0;
`endif
    end else begin
      rd_vld_q  <= rd_issue;
      rd_sos_q  <= rd_issue && (rd_state == RD_CP) && (rd_idx == CP_FIRST);
`ifdef CP_INSERT_TLAST_EN
      rd_last_q <= rd_done;
`endif
      case (rd_state)
        RD_IDLE: begin
          if (bank_st[rd_bank] == BANK_FULL) begin
            rd_state <= RD_CP;
            rd_idx   <= CP_FIRST;
          end
        end
        RD_CP: begin
          if (rd_issue) begin
            rd_idx <= rd_idx + 1'b1;
            if (rd_idx == IDX_LAST) rd_state <= RD_BODY;
          end
        end
        RD_BODY: begin
          if (rd_issue) begin
            if (rd_idx == IDX_LAST) begin
              // Bank just released; chain straight into the other one when
              // it already holds a symbol so the output stays gap-free.
              rd_bank  <= ~rd_bank;
              rd_idx   <= CP_FIRST;
              rd_state <= (bank_st[~rd_bank] == BANK_FULL) ? RD_CP : RD_IDLE;
            end else begin
              rd_idx <= rd_idx + 1'b1;
            end
          end
        end
        default: rd_state <= RD_IDLE;
      endcase
    end
  end

  // ------------------------------------------------------ output skid buffer
  always_comb begin
    push_beat      = '0;
    push_beat.data = ram_rd_data;
    push_beat.sos  = rd_sos_q;
`ifdef CP_INSERT_TLAST_EN
    push_beat.last = rd_last_q;
`endif
  end

  // Only two entries, so they are reset: tdata then reads 0 out of reset.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      skid[0]   <= '0;
      skid[1]   <= '0;
      skid_wptr <= 1'b0;
      skid_rptr <= 1'b0;
      skid_cnt  <= 2'd0;
    end else begin
      if (rd_vld_q) begin
        skid[skid_wptr] <= push_beat;
        skid_wptr       <= ~skid_wptr;
      end
      if (out_pop) skid_rptr <= ~skid_rptr;
      skid_cnt <= skid_cnt + {1'b0, rd_vld_q} - {1'b0, out_pop};
    end
  end

  // Outputs come straight from the skid registers, so a stalled beat and its
  // flags hold until accepted.
  assign m_axis_out.tvalid = (skid_cnt != 2'd0);
  assign m_axis_out.tdata  = skid[skid_rptr].data;
  assign symbol_start_o    = m_axis_out.tvalid && skid[skid_rptr].sos;
`ifdef CP_INSERT_TLAST_EN
  assign m_axis_out.tlast  = m_axis_out.tvalid && skid[skid_rptr].last;
`endif

endmodule : cp_insert

// File: tb/tb_cp_insert.sv
// -----------------------------------------------------------------------------
// tb_cp_insert
//   Self-checking bench for cp_insert. Accepted input samples are collected
//   per symbol; each completed symbol is expanded into its expected output
//   sequence (prefix, then body) in a queue that the output monitor consumes.
//   CP_LEN may be overridden at build time; CP_INSERT_TLAST_EN adds tlast
//   checking.
// -----------------------------------------------------------------------------
module tb_cp_insert #(
  parameter int CP_LEN = 18
);

  localparam int IN_DW   = 32;
  localparam int NFFT    = 8;
  localparam int FFT_LEN = 2**NFFT;
  localparam int SYM_OUT = FFT_LEN + CP_LEN;
  localparam int CLK_P   = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sos;

  always #(CLK_P/2) clk = ~clk;

  cp_insert_if #(.DW(IN_DW)) in_if ();
  cp_insert_if #(.DW(IN_DW)) out_if ();

  cp_insert #(
    .IN_DW  (IN_DW),
    .NFFT   (NFFT),
    .CP_LEN (CP_LEN)
  ) dut (
    .clk_i          (clk),
    .reset_ni       (rst_n),
    .s_axis_in      (in_if),
    .m_axis_out     (out_if),
    .symbol_start_o (sos)
  );

  // ----------------------------------------------------------- bookkeeping
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  typedef struct {
    logic [IN_DW-1:0] data;
    bit               sos;
    bit               last;
  } exp_t;

  exp_t             exp_q [$];
  logic [IN_DW-1:0] sym_buf [FFT_LEN];
  logic [IN_DW-1:0] out_log [$];

  // Stimulus controls (written by the main sequence only while idle).
  int  in_remaining = 0;
  bit  ramp = 1'b1;
  int  out_mode = 0;       // 0: tready low, 1: tready high, 2: random 50%

  int  in_xfers = 0;
  int  out_xfers = 0;
  int  in_stalls = 0;
  int  sym_wr = 0;
  int  sym_in_cnt = 0;
  int  sym_out_cnt = 0;
  int  sos_seen = 0;
  time sym_done_time = 0;
  time first_valid_time = 0;
  time last_xfer_time = 0;
  bit  seen_first = 1'b0;

  // Expand one stored symbol into its expected output beats.
  function automatic void push_symbol();
    exp_t e;
    for (int k = 0; k < CP_LEN; k++) begin
      e.data = sym_buf[FFT_LEN - CP_LEN + k];
      e.sos  = (k == 0);
      e.last = 1'b0;
      exp_q.push_back(e);
    end
    for (int n = 0; n < FFT_LEN; n++) begin
      e.data = sym_buf[n];
      e.sos  = 1'b0;
      e.last = (n == FFT_LEN - 1);
      exp_q.push_back(e);
    end
  endfunction

  // ---------------------------------------------------------- input driver
  bit               have = 1'b0;
  logic [IN_DW-1:0] cur = '0;

  always @(negedge clk) begin
`ifdef CP_INSERT_TLAST_EN
    in_if.tlast = 1'b0;
`endif
    if (!rst_n) begin
      in_if.tvalid = 1'b0;
      in_if.tdata  = '0;
      have         = 1'b0;
      sym_wr       = 0;
      sym_in_cnt   = 0;
    end else begin
      if (!have && in_remaining > 0) begin
        have = 1'b1;
        cur  = ramp ? IN_DW'(sym_wr) : IN_DW'($urandom);
      end
      in_if.tvalid = have;
      in_if.tdata  = have ? cur : '0;
      #1;
      if (rst_n && in_if.tvalid) begin
        if (in_if.tready) begin
          sym_buf[sym_wr] = cur;
          sym_wr++;
          in_xfers++;
          in_remaining--;
          have = 1'b0;
          if (sym_wr == FFT_LEN) begin
            push_symbol();
            sym_wr = 0;
            sym_in_cnt++;
            sym_done_time = $time;
          end
        end else begin
          in_stalls++;
          // Back-pressure is legal only with two whole symbols still stored.
          check("in_ready_low_needs_two_full", ((sym_in_cnt - sym_out_cnt) >= 2) ? 1 : 0, 1);
        end
      end
    end
  end

  // -------------------------------------------------------- output monitor
  bit               prev_stall = 1'b0;
  logic [IN_DW-1:0] prev_data = '0;
  logic             prev_sos = 1'b0;

  always @(negedge clk) begin
    case (out_mode)
      0:       out_if.tready = 1'b0;
      1:       out_if.tready = 1'b1;
      default: out_if.tready = 1'($urandom_range(0, 1));
    endcase
    #1;
    if (!rst_n) begin
      exp_q.delete();
      prev_stall  = 1'b0;
      sym_out_cnt = 0;
    end else begin
      if (prev_stall) begin
        check("stall_valid_held", out_if.tvalid, 1);
        check("stall_data_held", out_if.tdata, prev_data);
        check("stall_sos_held", sos, prev_sos);
      end
      if (!out_if.tvalid) begin
        check("sos_low_when_idle", sos, 0);
`ifdef CP_INSERT_TLAST_EN
        check("tlast_low_when_idle", out_if.tlast, 0);
`endif
      end else if (!seen_first) begin
        seen_first       = 1'b1;
        first_valid_time = $time;
      end
      if (out_if.tvalid && out_if.tready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", out_if.tdata, 64'hdead);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("out_data", out_if.tdata, e.data);
          check("out_sos", sos, e.sos);
`ifdef CP_INSERT_TLAST_EN
          check("out_tlast", out_if.tlast, e.last);
`endif
          if (e.last) sym_out_cnt++;
        end
        if (sos) sos_seen++;
        out_log.push_back(out_if.tdata);
        out_xfers++;
        last_xfer_time = $time;
      end
      prev_stall = out_if.tvalid && !out_if.tready;
      prev_data  = out_if.tdata;
      prev_sos   = sos;
    end
  end

  // ------------------------------------------------------------ helpers
  task automatic new_phase();
    out_xfers  = 0;
    in_xfers   = 0;
    in_stalls  = 0;
    sos_seen   = 0;
    seen_first = 1'b0;
    out_log.delete();
  endtask

  task automatic wait_out(input string name, input int target, input int budget);
    int n = 0;
    while (out_xfers < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    #2;
    check(name, out_xfers, target);
  endtask

  task automatic wait_in(input string name, input int target, input int budget);
    int n = 0;
    while (in_xfers < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    #2;
    check(name, in_xfers, target);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_tready"}, in_if.tready, 0);
    check({tag, "_out_tvalid"}, out_if.tvalid, 0);
    check({tag, "_out_tdata"}, out_if.tdata, 0);
    check({tag, "_sos"}, sos, 0);
  endtask

  // Ramp symbol: re = n, im = 0, so every output value follows from CP_LEN.
  task automatic check_ramp_pins(input string tag);
    logic [IN_DW-1:0] w;
    w = out_log[0];
    check({tag, "_first_re"}, w[15:0], FFT_LEN - CP_LEN);
    check({tag, "_first_im"}, w[31:16], 0);
    w = out_log[CP_LEN - 1];
    check({tag, "_cp_last_re"}, w[15:0], FFT_LEN - 1);
    w = out_log[CP_LEN];
    check({tag, "_body0_re"}, w[15:0], 0);
    w = out_log[SYM_OUT - 1];
    check({tag, "_end_re"}, w[15:0], FFT_LEN - 1);
    check({tag, "_sos_count"}, sos_seen, 1);
  endtask

  // ------------------------------------------------------------ watchdog
  initial begin
    #(CLK_P * 60000);
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  // ------------------------------------------------------- main sequence
  initial begin
    int lat;
    int span;
    out_if.tready = 1'b0;

    // Reset state.
    repeat (3) @(negedge clk);
    #2;
    check_reset_outputs("rst");
    rst_n = 1'b1;
    @(negedge clk);
    #2;
    check("tready_after_release", in_if.tready, 1);
    repeat (3) @(negedge clk);

    // Single ramp symbol, output always ready.
    new_phase();
    out_mode = 1;
    ramp = 1'b1;
    in_remaining = FFT_LEN;
    wait_out("p1_out_count", SYM_OUT, 2000);
    // Observation offsets: input fire is seen 4 time units before its edge,
    // output valid 6 after its edge, hence the extra cycle removed here.
    lat = int'((first_valid_time - sym_done_time) / CLK_P) - 1;
    check("p1_first_valid_latency_le3", (lat <= 3) ? 1 : 0, 1);
    repeat (20) @(negedge clk);
    #2;
    check("p1_no_extra_output", out_xfers, SYM_OUT);
    check_ramp_pins("p1");

    // Three back-to-back symbols, continuous input, output always ready.
    new_phase();
    ramp = 1'b0;
    in_remaining = 3 * FFT_LEN;
    wait_out("p2_out_count", 3 * SYM_OUT, 3000);
    span = int'((last_xfer_time - first_valid_time) / CLK_P) + 1;
    check("p2_gap_free_span", span, 3 * SYM_OUT);
    check("p2_backpressure_seen", (in_stalls > 0) ? 1 : 0, 1);
    repeat (10) @(negedge clk);

    // Four symbols with random output back-pressure.
    new_phase();
    out_mode = 2;
    in_remaining = 4 * FFT_LEN;
    wait_out("p3_out_count", 4 * SYM_OUT, 8000);
    check("p3_model_drained", exp_q.size(), 0);
    repeat (10) @(negedge clk);

    // Output held off: the input must stop after exactly two symbols.
    new_phase();
    out_mode = 0;
    in_remaining = 3 * FFT_LEN;
    wait_in("p4_in_two_symbols", 2 * FFT_LEN, 2000);
    repeat (50) @(negedge clk);
    #2;
    check("p4_in_stuck_at_two_symbols", in_xfers, 2 * FFT_LEN);
    check("p4_in_tready_low", in_if.tready, 0);
    check("p4_out_valid_held", out_if.tvalid, 1);
    check("p4_held_beat_is_cp0", out_if.tdata, exp_q[0].data);
    check("p4_held_beat_sos", sos, 1);
    out_mode = 1;
    wait_out("p4_out_count", 3 * SYM_OUT, 4000);
    repeat (10) @(negedge clk);

    // Reset in the middle of traffic.
    new_phase();
    in_remaining = 3 * FFT_LEN;
    begin
      int n = 0;
      while (out_xfers < 50 && n < 2000) begin
        @(negedge clk);
        n++;
      end
    end
    #2;
    check("p5_traffic_before_reset", ((in_xfers >= 100) && (out_xfers >= 50)) ? 1 : 0, 1);
    rst_n = 1'b0;
    in_remaining = 0;
    @(negedge clk);
    #2;
    check_reset_outputs("p5_rst");
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b1;
    @(negedge clk);
    #2;
    check("p5_tready_after_release", in_if.tready, 1);
    new_phase();
    repeat (20) @(negedge clk);
    #2;
    check("p5_no_stale_output", out_xfers, 0);
    ramp = 1'b1;
    in_remaining = FFT_LEN;
    wait_out("p5_out_count", SYM_OUT, 2000);
    repeat (10) @(negedge clk);
    #2;
    check_ramp_pins("p5");
    check("final_model_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_cp_insert
